park_gate_arbiter: RTL and testbench
====================================

# park_gate_arbiter

Single-lane barrier controller that shares one physical gate between the entry sensor and the exit sensor of the parking lot. It sequences open → car passes → close for one direction at a time, arbitrates simultaneous requests round-robin, refuses entry when the lot is full and refuses exit when it is empty, and owns the 4-bit car count. It sits after the debouncers, on the system clock, and replaces the free-running count FSM as the single owner of `CarCount`.

## Interface
Parameters:
- `CAPACITY`, 15: lot capacity, 1..15.
- `TIMEOUT`, 1000: cycles a granted gate stays open waiting for a car, 2..65535.

Ports:
- `Clk`, in, 1: system clock.
- `Reset`, in, 1: asynchronous, active-low reset.
- `ReqIn`, in, 1: debounced entry-sensor level; high = car waiting to enter.
- `ReqOut`, in, 1: debounced exit-sensor level; high = car waiting to leave.
- `PassSensor`, in, 1: debounced under-barrier sensor; high = vehicle in gate.
- `GrantIn`, out, 1: gate granted to entry direction.
- `GrantOut`, out, 1: gate granted to exit direction.
- `GateOpen`, out, 1: barrier open command.
- `Full`, out, 1: `CarCount == CAPACITY`.
- `Empty`, out, 1: `CarCount == 0`.
- `Abort`, out, 1: one-cycle pulse when a grant times out.
- `CarCount`, out, 4: cars in the lot.

## Operation
- States: IDLE, OPEN, PASS, CLOSE. Reset enters IDLE.
- Eligibility, evaluated in IDLE:
  - Entry is eligible when `ReqIn & ArmIn & !Full & !PassSensor`.
  - Exit is eligible when `ReqOut & ArmOut & !Empty & !PassSensor`.
- Re-arm: a side's `Arm` flag clears when that side is granted. It sets again on any cycle its request is low. Both flags are set at reset. A car that stays parked on a sensor is therefore never granted twice.
- Arbitration:
  - If exactly one side is eligible, it is granted.
  - If both are eligible, grant the side opposite `LastDir`. `LastDir` resets to exit, so the first tie goes to entry. `LastDir` updates on every grant.
- IDLE → OPEN on a grant. `Dir` is registered. `GateOpen=1`. `GrantIn` or `GrantOut` is 1 per `Dir`. The timeout counter is cleared.
- OPEN → PASS when `PassSensor=1`.
- OPEN → CLOSE on timeout, with `Abort` pulsed and no count change.
- PASS → CLOSE when `PassSensor=0`. On that edge `CarCount` is incremented for entry or decremented for exit.
- PASS has no timeout. The gate never closes while `PassSensor=1`.
- CLOSE → IDLE unconditionally. In CLOSE, `GateOpen` and both grants are 0.
- Count saturates at `CAPACITY` and 0. Eligibility makes overflow unreachable; saturation is a backstop.
- Requests and `PassSensor` are ignored outside IDLE, except that the Arm flags keep tracking request lows.

## Timing
- Reset values: state IDLE, `GateOpen=0`, `GrantIn=0`, `GrantOut=0`, `Abort=0`, `CarCount=0`, `Empty=1`, `Full=0`, `LastDir=exit`, `ArmIn=ArmOut=1`, timer 0.
- Reset asserted mid-operation immediately closes the gate and clears the count.
- All outputs are registered.
- A request sampled high at edge t gives `GateOpen`/grant high from t+1.
- `PassSensor` sampled high at edge k moves the FSM to PASS at k+1.
- `PassSensor` sampled low in PASS at edge m:
  - `CarCount`, `Full` and `Empty` take their new values after m.
  - `GateOpen` falls after m.
  - IDLE is reached after m+1.
  - The earliest next grant is after m+2.
- Timeout: the gate falls, and `Abort` is high for one cycle, `TIMEOUT` cycles after `GateOpen` rose, if `PassSensor` stayed low.
- Simultaneous request and `PassSensor` high in IDLE: no grant.

## Configuration
- `PARK_GATE_TIMEOUT_EN`:
  - Defined: OPEN times out as described.
  - Undefined: OPEN waits indefinitely for `PassSensor`, `Abort` is tied to 0, and the timer is not built.

## Test plan
- Reset, then `ReqIn` pulse and `PassSensor` 1 then 0 → `GrantIn` and `GateOpen` rise 1 cycle after the request; `CarCount` goes 0→1 on the `PassSensor` fall; gate closes; `Empty` falls.
- `ReqIn` and `ReqOut` both high from IDLE with `CarCount=3`, three passes with requests dropped and reraised between → grants go entry, exit, entry; count goes 3→4→3→4.
- `CAPACITY=2`, count at 2, `ReqIn` high → no grant and `Full=1`; concurrent `ReqOut` is granted, count goes to 1, and entry is then granted.
- `ReqIn` held high through a full cycle without dropping → exactly one grant; a second grant comes only after `ReqIn` low for ≥1 cycle.
- Macro defined, `TIMEOUT=10`, grant with no pass → `GateOpen` high for exactly 10 cycles, `Abort` pulses once, count unchanged. `PassSensor` held high for 50 cycles in PASS → gate stays open.
- `Reset` asserted while in PASS with count 5 → `GateOpen`, grants and `CarCount` go to 0 immediately; FSM is in IDLE on release.

Source files
------------

// File: rtl/park_gate_arbiter.sv
// One-lane barrier shared by the entry and exit sensors: round-robin on ties, owner of CarCount, all outputs registered.
// A grant appears one cycle after its request, with no backpressure. Define PARK_GATE_TIMEOUT_EN to enable the open-gate timeout and Abort.
module park_gate_arbiter #(
  parameter int CAPACITY = 15,
  parameter int TIMEOUT  = 1000
) (
  input  logic       Clk,
  input  logic       Reset,
  input  logic       ReqIn,
  input  logic       ReqOut,
  input  logic       PassSensor,
  output logic       GrantIn,
  output logic       GrantOut,
  output logic       GateOpen,
  output logic       Full,
  output logic       Empty,
  output logic       Abort,
  output logic [3:0] CarCount
);

  typedef enum logic [1:0] {IDLE, OPEN, PASS, CLOSE} state_t;

  localparam logic [3:0] CAP = 4'(CAPACITY);

  if (CAPACITY < 1 || CAPACITY > 15 || TIMEOUT < 2 || TIMEOUT > 65535) begin : g_param_check
    $error("park_gate_arbiter: CAPACITY or TIMEOUT out of range");
  end

  state_t     state, state_nxt;
  logic       dir;        // 1 = exit direction owns the gate
  logic       last_dir;
  logic       arm_in, arm_out;
  logic       elig_in, elig_out;
  logic       grant_vld, grant_dir, dir_nxt;
  logic       gate_nxt;
  logic       timeout_hit;
  logic [3:0] count_nxt;

  always_comb begin
    elig_in   = ReqIn  & arm_in  & ~Full  & ~PassSensor;
    elig_out  = ReqOut & arm_out & ~Empty & ~PassSensor;
    grant_vld = (state == IDLE) && (elig_in || elig_out);
    grant_dir = (elig_in && elig_out) ? ~last_dir : elig_out;
    dir_nxt   = grant_vld ? grant_dir : dir;
    state_nxt = state;
    count_nxt = CarCount;
    case (state)
      IDLE: begin
        if (grant_vld) state_nxt = OPEN;
      end
      OPEN: begin
        if (PassSensor)       state_nxt = PASS;
        else if (timeout_hit) state_nxt = CLOSE;
      end
      PASS: begin
        // The count moves on the falling edge of the pass sensor; saturation is only a backstop.
        if (!PassSensor) begin
          state_nxt = CLOSE;
          if (!dir) begin
            if (CarCount < CAP) count_nxt = CarCount + 4'd1;
          end else if (CarCount != 4'd0) begin
            count_nxt = CarCount - 4'd1;
          end
        end
      end
      CLOSE:   state_nxt = IDLE;
      default: state_nxt = IDLE;
    endcase
    gate_nxt = (state_nxt == OPEN) || (state_nxt == PASS);
  end

  always_ff @(posedge Clk or negedge Reset) begin
    if (!Reset) begin
      state    <= IDLE;
      dir      <= 1'b0;
      last_dir <= 1'b1;
      arm_in   <= 1'b1;
      arm_out  <= 1'b1;
      GateOpen <= 1'b0;
      GrantIn  <= 1'b0;
      GrantOut <= 1'b0;
      CarCount <= 4'd0;
      Full     <= 1'b0;
      Empty    <= 1'b1;
    end else begin
      state    <= state_nxt;
      dir      <= dir_nxt;
      if (grant_vld) last_dir <= grant_dir;
      // A side is re-armed only by seeing its request low, so a parked car cannot be granted twice.
      if (!ReqIn)                        arm_in  <= 1'b1;
      else if (grant_vld && !grant_dir)  arm_in  <= 1'b0;
      if (!ReqOut)                       arm_out <= 1'b1;
      else if (grant_vld && grant_dir)   arm_out <= 1'b0;
      GateOpen <= gate_nxt;
      GrantIn  <= gate_nxt & ~dir_nxt;
      GrantOut <= gate_nxt &  dir_nxt;
      CarCount <= count_nxt;
      Full     <= (count_nxt == CAP);
      Empty    <= (count_nxt == 4'd0);
    end
  end

`ifdef PARK_GATE_TIMEOUT_EN
  localparam logic [15:0] TIMER_LAST = 16'(TIMEOUT - 1);

  logic [15:0] timer;

  assign timeout_hit = (timer == TIMER_LAST);

  always_ff @(posedge Clk or negedge Reset) begin
    if (!Reset) begin
      timer <= 16'd0;
      Abort <= 1'b0;
    end else begin
      Abort <= (state == OPEN) && !PassSensor && timeout_hit;
      if (grant_vld)           timer <= 16'd0;
      else if (state == OPEN)  timer <= timer + 16'd1;
    end
  end
`else
  assign timeout_hit = 1'b0;
  assign Abort       = 1'b0;
`endif

endmodule

// File: tb/tb_park_gate_arbiter.sv
// Randomised and directed bench for park_gate_arbiter, checked against a transaction-level model of one gate session.
module tb_park_gate_arbiter;

  localparam int CAP = 3;
  localparam int TO  = 10;
`ifdef PARK_GATE_TIMEOUT_EN
  localparam bit TO_EN = 1'b1;
`else
  localparam bit TO_EN = 1'b0;
`endif

  logic       Clk = 1'b0;
  logic       Reset;
  logic       ReqIn, ReqOut, PassSensor;
  logic       GrantIn, GrantOut, GateOpen, Full, Empty, Abort;
  logic [3:0] CarCount;

  int tests = 0;
  int fails = 0;

  park_gate_arbiter #(.CAPACITY(CAP), .TIMEOUT(TO)) dut (
    .Clk(Clk), .Reset(Reset), .ReqIn(ReqIn), .ReqOut(ReqOut), .PassSensor(PassSensor),
    .GrantIn(GrantIn), .GrantOut(GrantOut), .GateOpen(GateOpen), .Full(Full),
    .Empty(Empty), .Abort(Abort), .CarCount(CarCount)
  );

  always #5 Clk = ~Clk;

  // Model: a "session" is the life of one grant; it ends with a one-cycle closing phase.
  bit m_busy, m_closing, m_car, m_dir, m_last, m_arm_in, m_arm_out, m_abort;
  int m_age, m_count;

  task automatic model_reset();
    m_busy = 0; m_closing = 0; m_car = 0; m_dir = 0; m_last = 1;
    m_arm_in = 1; m_arm_out = 1; m_abort = 0; m_age = 0; m_count = 0;
  endtask

  task automatic model_step(input bit ri, input bit ro, input bit ps);
    bit ein, eout, granted, gdir;
    granted = 0; gdir = 0; m_abort = 0;
    if (!m_busy) begin
      ein  = ri && m_arm_in  && (m_count != CAP) && !ps;
      eout = ro && m_arm_out && (m_count != 0)   && !ps;
      if (ein && eout) gdir = !m_last;
      else             gdir = eout;
      if (ein || eout) begin
        granted = 1; m_busy = 1; m_dir = gdir; m_last = gdir;
        m_age = 0; m_car = 0; m_closing = 0;
      end
    end else if (m_closing) begin
      m_busy = 0; m_closing = 0;
    end else if (!m_car) begin
      if (ps) m_car = 1;
      else begin
        m_age = m_age + 1;
        if (TO_EN && m_age == TO) begin m_closing = 1; m_abort = 1; end
      end
    end else if (!ps) begin
      m_closing = 1;
      if (!m_dir) m_count = (m_count < CAP) ? m_count + 1 : CAP;
      else        m_count = (m_count > 0) ? m_count - 1 : 0;
    end
    if (!ri) m_arm_in = 1;
    else if (granted && !gdir) m_arm_in = 0;
    if (!ro) m_arm_out = 1;
    else if (granted && gdir) m_arm_out = 0;
  endtask

  initial begin
    model_reset();
    forever begin
      @(posedge Clk or negedge Reset);
      if (!Reset) model_reset();
      else        model_step(ReqIn, ReqOut, PassSensor);
    end
  end

  task automatic check(input string name, input int act, input int exp);
    tests = tests + 1;
    if (act != exp) begin
      fails = fails + 1;
      $display("FAIL %s: got %0d, expected %0d (t=%0t)", name, act, exp, $time);
    end
  endtask

  initial begin
    forever begin
      @(negedge Clk);
      check("model GateOpen", GateOpen, int'(m_busy && !m_closing));
      check("model GrantIn",  GrantIn,  int'(m_busy && !m_closing && !m_dir));
      check("model GrantOut", GrantOut, int'(m_busy && !m_closing && m_dir));
      check("model CarCount", CarCount, m_count);
      check("model Full",     Full,     int'(m_count == CAP));
      check("model Empty",    Empty,    int'(m_count == 0));
      check("model Abort",    Abort,    int'(m_abort));
    end
  end

  // Called at a negedge: apply inputs, then return at the next negedge with outputs of the edge between.
  task automatic drive(input bit ri, input bit ro, input bit ps);
    ReqIn = ri; ReqOut = ro; PassSensor = ps;
    @(negedge Clk);
  endtask

  initial begin
    Reset = 1'b0; ReqIn = 0; ReqOut = 0; PassSensor = 0;
    repeat (3) @(negedge Clk);
    check("reset GateOpen", GateOpen, 0);
    check("reset CarCount", CarCount, 0);
    check("reset Empty",    Empty,    1);
    check("reset Full",     Full,     0);
    Reset = 1'b1;

    // Single entry pass.
    drive(1, 0, 0);
    check("entry GrantIn",  GrantIn,  1);
    check("entry GateOpen", GateOpen, 1);
    drive(0, 0, 0);
    drive(0, 0, 1);
    drive(0, 0, 0);
    check("entry close GateOpen", GateOpen, 0);
    check("entry CarCount", CarCount, 1);
    check("entry Empty",    Empty,    0);
    drive(0, 0, 0);

    // Tie after an entry grant goes to exit.
    drive(1, 1, 0);
    check("tie1 GrantOut", GrantOut, 1);
    check("tie1 GrantIn",  GrantIn,  0);
    drive(0, 0, 1);
    drive(0, 0, 0);
    check("tie1 CarCount", CarCount, 0);
    drive(0, 0, 0);

    // Both requests with lot empty: exit refused, entry granted.
    drive(1, 1, 0);
    check("empty tie GrantIn", GrantIn, 1);
    drive(0, 0, 1);
    drive(0, 0, 0);
    drive(0, 0, 0);

    // Held request: one grant only until it drops.
    drive(1, 0, 0);
    check("held GrantIn", GrantIn, 1);
    drive(1, 0, 1);
    drive(1, 0, 0);
    check("held CarCount", CarCount, 2);
    drive(1, 0, 0);
    drive(1, 0, 0);
    check("held no regrant", GateOpen, 0);
    drive(0, 0, 0);

    // Request together with an occupied sensor in IDLE is refused.
    drive(1, 0, 1);
    check("sensor blocks grant", GateOpen, 0);
    drive(0, 0, 0);
    drive(1, 0, 0);
    check("rearm GrantIn", GrantIn, 1);

`ifdef PARK_GATE_TIMEOUT_EN
    repeat (TO - 1) drive(0, 0, 0);
    check("timeout still open", GateOpen, 1);
    drive(0, 0, 0);
    check("timeout GateOpen", GateOpen, 0);
    check("timeout Abort",    Abort,    1);
    check("timeout CarCount", CarCount, 2);
    drive(0, 0, 0);
    check("abort one cycle",  Abort,    0);
    drive(1, 0, 0);
    check("after abort GrantIn", GrantIn, 1);
`endif

    // Long dwell under the barrier keeps the gate open.
    drive(0, 0, 1);
    repeat (50) drive(0, 0, 1);
    check("dwell GateOpen", GateOpen, 1);
    drive(0, 0, 0);
    check("fill CarCount", CarCount, 3);
    check("fill Full",     Full,     1);
    drive(0, 0, 0);
    drive(1, 0, 0);
    check("full refuses entry", GateOpen, 0);
    drive(1, 1, 0);
    check("full exit GrantOut", GrantOut, 1);
    drive(0, 0, 1);
    drive(0, 0, 0);
    check("exit CarCount", CarCount, 2);

    // Random traffic with occasional asynchronous resets.
    for (int i = 0; i < 4000; i++) begin
      if (i % 800 == 400) begin
        @(posedge Clk);
        #2 Reset = 1'b0;
        #1;
        check("async reset GateOpen", GateOpen, 0);
        check("async reset GrantIn",  GrantIn,  0);
        check("async reset GrantOut", GrantOut, 0);
        check("async reset CarCount", CarCount, 0);
        @(negedge Clk);
        Reset = 1'b1;
      end else begin
        if ($urandom_range(3) == 0) ReqIn  = ~ReqIn;
        if ($urandom_range(3) == 0) ReqOut = ~ReqOut;
        if ($urandom_range(2) == 0) PassSensor = ~PassSensor;
        @(negedge Clk);
      end
    end

    $display("[TB] %0d tests run, %0d failed", tests, fails);
    $finish;
  end

endmodule
